// File: rtl/dice_roll_ctrl.sv
// dice_roll_ctrl: roll sequencer for the dice counter.
// A roll request starts a burst of one-clk step pulses: a fast phase of
// FAST_MIN + L steps (L from a free-running LFSR), one per tick, then a
// decelerating tail of SLOW_STEPS steps spaced 2,4,8,... ticks apart,
// followed by a one-cycle done pulse that coincides with the last step.
//
// Ports:
//   clk      in   system clock (32768 Hz)
//   rst      in   asynchronous active-high reset
//   tick     in   one-clk 32 Hz prescaler pulse
//   roll_req in   debounced roll button (level, rising edge starts a roll)
//   cancel   in   synchronous abort (level)
//   step     out  registered one-clk decrement pulse to the die counter
//   busy     out  high in FAST or SLOW
//   slow     out  high in SLOW
//   done     out  high for the single DONE cycle
module dice_roll_ctrl #(
   parameter int FAST_MIN   = 24,
   parameter int SLOW_STEPS = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic roll_req,
   input  logic cancel,
   output logic step,
   output logic busy,
   output logic slow,
   output logic done
);

   typedef enum logic [1:0] {IDLE, FAST, SLOW, DONE} state_t;

   state_t      state, state_nx;
   logic        roll_q;
   logic [7:0]  lfsr;
   logic [5:0]  fast_n;
   logic [5:0]  fast_cnt;
   logic [6:0]  ivl;
   logic [2:0]  k;
   logic        start, fast_last, slow_hit, slow_last;

   // start needs a fresh rising edge and is held off while cancel is high
   assign start     = roll_req & ~roll_q & ~cancel;
   assign fast_last = (fast_cnt + 6'd1) == fast_n;
   // slow step k fires when the interval reaches 2^(k+1) ticks (max 64)
   assign slow_hit  = (ivl + 7'd1) == (7'd2 << k);
   assign slow_last = slow_hit && (k == 3'(SLOW_STEPS - 1));

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // next-state logic; cancel outranks tick and a completing step
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (start) state_nx = FAST;
         FAST: begin
            if (cancel)                  state_nx = IDLE;
            else if (tick && fast_last)  state_nx = SLOW;
         end
         SLOW: begin
            if (cancel)                  state_nx = IDLE;
            else if (tick && slow_last)  state_nx = DONE;
         end
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      busy = 1'b0;
      slow = 1'b0;
      done = 1'b0;
      case (state)
         FAST: busy = 1'b1;
         SLOW: begin busy = 1'b1; slow = 1'b1; end
         DONE: done = 1'b1;
         default: ;
      endcase
   end

   // datapath: LFSR, edge detector, counters and the registered step
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr     <= 8'h01;
         roll_q   <= 1'b0;
         step     <= 1'b0;
         fast_n   <= '0;
         fast_cnt <= '0;
         ivl      <= '0;
         k        <= '0;
      end else begin
         lfsr   <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
         roll_q <= roll_req;
         step   <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  fast_n   <= 6'(FAST_MIN) + {1'b0, lfsr[4:0]};
                  fast_cnt <= '0;
                  ivl      <= '0;
                  k        <= '0;
               end
            end
            FAST: begin
               if (cancel) begin
                  fast_cnt <= '0;
                  fast_n   <= '0;
                  ivl      <= '0;
                  k        <= '0;
               end else if (tick) begin
                  step     <= 1'b1;
                  fast_cnt <= fast_cnt + 6'd1;
                  if (fast_last) begin
                     ivl <= '0;
                     k   <= '0;
                  end
               end
            end
            SLOW: begin
               if (cancel) begin
                  fast_cnt <= '0;
                  fast_n   <= '0;
                  ivl      <= '0;
                  k        <= '0;
               end else if (tick) begin
                  if (slow_hit) begin
                     step <= 1'b1;
                     ivl  <= '0;
                     k    <= k + 3'd1;
                  end else begin
                     ivl <= ivl + 7'd1;
                  end
               end
            end
            default: begin
               fast_cnt <= '0;
               fast_n   <= '0;
               ivl      <= '0;
               k        <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/dice_roll_ctrl.md
# dice_roll_ctrl

Roll sequencer for the dice counter. On a roll request it issues a burst of one-clock `step` pulses to the BCD die counter: a fast spin of pseudo-random length, then a decelerating tail, then a completion pulse. This makes the displayed result random and visibly "spin down". It sits between the button debouncers, the 32 Hz prescaler tick and the die counter's decrement input.

## Interface

Parameters:
- FAST_MIN, 24: minimum fast-phase step count; legal range 1..32.
- SLOW_STEPS, 4: number of slow-phase steps; legal range 1..6.

Ports:
- clk  in  1  system clock, 32768 Hz.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  one-clk pulse at 32 Hz from the prescaler.
- roll_req  in  1  debounced roll button, level.
- cancel  in  1  synchronous abort, level.
- step  out  1  one-clk decrement pulse to the die counter.
- busy  out  1  high while in FAST or SLOW.
- slow  out  1  high while in SLOW, used for the display blink.
- done  out  1  one-clk pulse when a roll completes.

## Operation

- Design style: single clock domain. All flops are reset asynchronously by `rst`.
- On `rst`:
  - state=IDLE.
  - step=busy=slow=done=0.
  - roll_q=0.
  - lfsr=8'h01.
  - All counters are 0.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Update: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - Advances every clk in every state.
- Start condition: roll_req & ~roll_q & state==IDLE, where roll_q is roll_req registered every clk.
- FSM states: IDLE, FAST, SLOW, DONE.
- Start: state -> FAST. Capture L = lfsr[4:0] (pre-update value at that edge). N = FAST_MIN + L, a 6-bit value. fast_cnt <= 0.
- FAST:
  - Each sampled tick gives step=1 and fast_cnt+1.
  - On the tick that makes N steps, go to SLOW with k=0, ivl=0.
- SLOW:
  - Each tick increments ivl (7-bit).
  - On the tick where ivl+1 == 2^(k+1), give step=1, ivl <= 0, k+1.
  - On the tick giving the SLOW_STEPS-th slow step, go to DONE.
- DONE:
  - Lasts exactly one cycle, then goes to IDLE.
  - No new roll can start in the DONE cycle.
- Total steps per completed roll = FAST_MIN + L + SLOW_STEPS.
- Ignored inputs:
  - tick in IDLE and DONE.
  - roll_req edges while state != IDLE.
  - roll_req held high does not retrigger.
- Cancel, in FAST or SLOW:
  - Next state is IDLE, counters are cleared, and step=0 in that cycle even if tick=1.
  - done is not asserted.
  - cancel has priority over tick and over a completing step.
  - cancel in IDLE: a start is still suppressed while cancel=1.

## Timing

- Outputs:
  - step is registered.
  - busy, slow and done are decoded from the registered state: busy=(FAST|SLOW), slow=SLOW, done=DONE.
- Start latency: busy rises in the cycle after the edge that samples the roll_req rising edge.
- A tick sampled at the start edge is ignored.
- Tick-to-step latency is 1 clk: step is high in the cycle following the edge that sampled tick=1.
- Fast steps are spaced one tick apart (1024 clk at nominal prescale).
- Slow step k follows the previous step by 2^(k+1) ticks: 2, 4, 8, 16 ticks for the default.
- Final step:
  - step=1 and done=1 in the same cycle; busy=0 in that cycle.
  - done drops the next cycle.
  - The next roll may start on the edge after done (state IDLE).
- rst mid-roll: all outputs drop to 0 immediately (asynchronously). No done is emitted.

## Test plan

- Reset:
  - Stimulus: assert rst, then release.
  - Required: step/busy/slow/done=0; lfsr=8'h01; tick pulses with roll_req=0 give no step for 2048 clks.
- Full roll, default parameters:
  - Stimulus: after reset release, raise roll_req at cycle C.
  - Required:
    - Bench model of the LFSR gives L.
    - Exactly 28+L step pulses.
    - First 24+L steps one tick apart; slow high after the last fast step.
    - Slow gaps of 2/4/8/16 ticks.
    - done coincident with the final step; busy=0 in that cycle.
- Retrigger rejection:
  - Stimulus: roll_req held high through the whole roll, plus extra pulses during FAST and SLOW and in the DONE cycle.
  - Required: exactly one roll of 28+L steps.
- Cancel mid-FAST, after 5 steps:
  - Stimulus: cancel asserted in a cycle with tick=1.
  - Required: no step that cycle; busy=0 the next cycle; done never asserts; a subsequent roll_req edge starts a fresh roll.
- Async reset mid-SLOW (k=2):
  - Required: step/busy/slow drop without waiting for a clk edge; lfsr=8'h01; no done.
- Parameter corner FAST_MIN=32, SLOW_STEPS=6:
  - Stimulus: force L=31 by timing roll_req.
  - Required: 63 fast steps, then slow gaps 2..64 ticks (ivl reaches 63 without overflow), then done.
